// File: rtl/mux_arbiter.sv
// mux_arbiter: packet-granular controller for a 2:1 router output mux.
// Optional watchdog release is compiled in with `define MUX_ARB_TIMEOUT_EN.
module mux_arbiter #(
   parameter int VCHW       = 1,
   parameter int CREDIT_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ivalid_0,
   input  logic            ivalid_1,
   input  logic [1:0]      itype_0,
   input  logic [1:0]      itype_1,
   input  logic [VCHW-1:0] ivch_0,
   input  logic [VCHW-1:0] ivch_1,
   input  logic            credit_in,
   input  logic [VCHW-1:0] credit_vch,
   output logic [1:0]      sel,
   output logic            grant_0,
   output logic            grant_1,
   output logic            busy,
   output logic            err_ovf,
   output logic            timeout
);

   localparam int NVC = 1 << VCHW;
   localparam int CW  = $clog2(CREDIT_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] TAIL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            rr_q, rr_d;
   logic [VCHW-1:0] lvch_q, lvch_d;
   logic            err_q, err_d;
   logic [CW-1:0]   credit_q [NVC];
   logic [CW-1:0]   credit_d [NVC];
   logic [NVC-1:0]  ret_v, use_v;
   logic            req_0, req_1, lcred, grant, wd_fire;

   assign req_0 = ivalid_0 && (itype_0 == HEAD) && (credit_q[ivch_0] != '0);
   assign req_1 = ivalid_1 && (itype_1 == HEAD) && (credit_q[ivch_1] != '0);
   assign lcred = credit_q[lvch_q] != '0;

   assign grant_0 = (state_q == LOCK0) && ivalid_0 && lcred;
   assign grant_1 = (state_q == LOCK1) && ivalid_1 && lcred;
   assign grant   = grant_0 || grant_1;
   assign sel     = {state_q == LOCK1, state_q == LOCK0};
   assign busy    = state_q != IDLE;
   assign err_ovf = err_q;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wd_q, wd_d;

   // watchdog: count consecutive grant-less lock cycles, fire at TIMEOUT
   always_comb begin
      wd_d    = '0;
      wd_fire = 1'b0;
      if (busy && !grant) begin
         if (wd_q == TW'(TIMEOUT - 1)) begin
            wd_fire = 1'b1;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
   end

   // watchdog counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   assign timeout = wd_fire;
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   // arbitrate on HEADs in IDLE, hold the lock until a granted TAIL
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lvch_d  = lvch_q;
      unique case (state_q)
         IDLE: begin
            if (req_0 && !(req_1 && rr_q)) begin
               state_d = LOCK0;
               lvch_d  = ivch_0;
            end else if (req_1) begin
               state_d = LOCK1;
               lvch_d  = ivch_1;
            end
         end
         LOCK0: begin
            if (grant_0 && itype_0 == TAIL) begin
               state_d = IDLE;
               rr_d    = 1'b1;
            end
         end
         LOCK1: begin
            if (grant_1 && itype_1 == TAIL) begin
               state_d = IDLE;
               rr_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wd_fire) begin
         state_d = IDLE;
         rr_d    = ~rr_q;
      end
   end

   // per-VC return and consume strobes
   always_comb begin
      ret_v = '0;
      use_v = '0;
      for (int v = 0; v < NVC; v++) begin
         ret_v[v] = credit_in && (credit_vch == VCHW'(v));
         use_v[v] = grant && (lvch_q == VCHW'(v));
      end
   end

   // credit counters; a return to a full counter is dropped and flagged
   always_comb begin
      err_d = err_q;
      for (int v = 0; v < NVC; v++) begin
         credit_d[v] = credit_q[v];
         if (ret_v[v] && !use_v[v]) begin
            if (credit_q[v] == CMAX) begin
               err_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + 1'b1;
            end
         end else if (use_v[v] && !ret_v[v]) begin
            credit_d[v] = credit_q[v] - 1'b1;
         end
      end
   end

   // state, pointer, locked VC, credits and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         lvch_q  <= '0;
         err_q   <= 1'b0;
         for (int v = 0; v < NVC; v++) begin
            credit_q[v] <= CMAX;
         end
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lvch_q  <= lvch_d;
         err_q   <= err_d;
         for (int v = 0; v < NVC; v++) begin
            credit_q[v] <= credit_d[v];
         end
      end
   end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Packet-granular controller for the 2:1 router output mux. Arbitrates between input ports 0 and 1 on HEAD flits, locks the winning port and its virtual channel (VC) until the TAIL flit is transferred, and paces flits against per-VC downstream credits. It drives the mux `sel` and per-port grant handshakes. It sits between the input buffers and the mux, once per output port.

## Interface
Parameters:
- `VCHW`, 1: VC field width; the block tracks 2^VCHW credit counters.
- `CREDIT_MAX`, 4: credits per VC after reset; counter width is clog2(CREDIT_MAX+1).
- `TIMEOUT`, 16: watchdog limit in cycles; used only with `MUX_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ivalid_0` / `ivalid_1` in 1: the port holds a flit.
- `itype_0` / `itype_1` in 2: flit type (the top 2 bits of `idata_x`). NONE=00, HEAD=01, DATA=10, TAIL=11.
- `ivch_0` / `ivch_1` in VCHW: VC of the flit.
- `credit_in` in 1: one-cycle credit return pulse from downstream.
- `credit_vch` in VCHW: VC being credited.
- `sel` out 2: one-hot mux select. 01=port0, 10=port1, 00=none.
- `grant_0` / `grant_1` out 1: flit on that port transfers this cycle; the port advances.
- `busy` out 1: a packet is locked.
- `err_ovf` out 1: sticky; a credit was returned to a full counter.
- `timeout` out 1: one-cycle pulse on watchdog release. Tied 0 when the watchdog is compiled out.

## Operation
- FSM has three states: IDLE, LOCK0, LOCK1. `sel`=00 in IDLE, 01 in LOCK0, 10 in LOCK1. `busy` = state≠IDLE.
- Request from port x: `ivalid_x` && `itype_x`==HEAD && credit[`ivch_x`]>0. Non-HEAD flits are never granted while in IDLE.
- Arbitration in IDLE:
  - One request: that port wins.
  - Both request: the port indicated by the round-robin pointer `rr` wins. `rr` resets to 0.
  - On a win: go to LOCKx and register the locked VC `lvch` = `ivch_x`.
- Grant in LOCKx: `grant_x` = `ivalid_x` && credit[`lvch`]>0. The other grant is 0. Grants are combinational from state, inputs and credits.
- Each cycle with `grant_x`=1, credit[`lvch`] decrements by 1.
- A granted TAIL returns the FSM to IDLE on the next edge and sets `rr` to the other port.
- Credit counters:
  - `credit_in` increments credit[`credit_vch`].
  - Return and consume on the same VC in the same cycle: the count is unchanged.
  - Return to a counter already at CREDIT_MAX: the counter holds and `err_ovf` sets. `err_ovf` clears only on reset.
- A HEAD seen while locked is granted as an ordinary flit. The block does no packet-format checking.

## Timing
- Reset values:
  - `sel`=00, `grant_x`=0, `busy`=0, `err_ovf`=0, `timeout`=0.
  - State IDLE, `rr`=0, `lvch`=0, all credits=CREDIT_MAX.
- Reset asserted mid-packet aborts the lock; outputs take reset values from the next edge.
- Arbitration latency: a HEAD presented in cycle t (counters nonzero) is granted in t+1. The port must hold the HEAD until its grant.
- Throughput in lock: one flit per cycle while `ivalid_x` is high and credits last.
- Credit stall:
  - credit[`lvch`]=0 forces `grant_x`=0.
  - A credit returned in cycle t is usable for a grant in t+1.
- Release: a TAIL granted in cycle t puts the FSM in IDLE in t+1. The earliest next grant is t+2, so there is one dead cycle between packets.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A counter counts consecutive LOCK cycles with no grant, and clears on any grant.
  - When the count reaches TIMEOUT, the FSM forces IDLE, flips `rr` and pulses `timeout` for one cycle. Credits are untouched.
- `MUX_ARB_TIMEOUT_EN` undefined: no counter; the lock is held indefinitely; `timeout` is constant 0.

## Test plan
- Reset, then port1 sends HEAD, DATA×3, TAIL on VC0 (CREDIT_MAX=4, one credit return per flit) → `sel`=10 one cycle after HEAD; 5 grants; `sel`=00 the cycle after the TAIL grant.
- Both ports present HEAD at the same cycle, twice in a row → port0 wins first (`rr`=0), port1 wins second; `sel` sequence 01, 00, 10.
- 6-flit packet on VC1 with no credit returns → 4 grants, then `grant`=0 with `busy`=1. A `credit_in` on VC1 gives a grant the next cycle.
- `credit_in` on VC0 in the same cycle a VC0 flit is granted with the counter at 2 → the counter stays 2. Two further returns at count 4 → holds 4 and `err_ovf`=1 until `rst`.
- `rst` pulsed while in LOCK0 with credits at 1 → the next cycle shows `sel`=00, `busy`=0 and credits=4.
- With `MUX_ARB_TIMEOUT_EN`: lock port0, then drop `ivalid_0` for 16 cycles → `timeout` pulses once, `busy`=0, and a pending port1 HEAD is granted afterwards.
